// File: rtl/wbuffer_ctrl.sv
// ============================================================================
// wbuffer_ctrl : fetch/load/shift sequencer for the four-register weight buffer
// Optional ack watchdog and sticky err port: define WBUF_CTRL_TIMEOUT_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module wbuffer_ctrl #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned NUM_WORDS   = 256,
  parameter int unsigned SRAM_BASE   = 0,
  parameter int unsigned SDRAM_BASE  = 0,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic              advance,
  output logic              sram_req,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic              sram_ack,
  output logic              sdram_req,
  output logic [ADDR_W-1:0] sdram_addr,
  input  logic              sdram_ack,
  output logic              buf_enable,
  output logic [2:0]        buf_mode,
  output logic              pair_valid,
  output logic              busy,
  output logic              done
`ifdef WBUF_CTRL_TIMEOUT_EN
  ,
  output logic              err
`endif
);

  localparam int KW = $clog2(NUM_WORDS + 1);

  typedef enum logic [3:0] {
    IDLE, F1S, F1D, F2S, F2D, READY, SHIFT, RS, RD, DONE
  } state_t;

  state_t          state_q, state_d;
  logic [KW-1:0]   k_q, k_d;
  logic [KW-1:0]   c_q, c_d;

  assign sram_addr  = ADDR_W'(SRAM_BASE)  + ADDR_W'(k_q);
  assign sdram_addr = ADDR_W'(SDRAM_BASE) + ADDR_W'(k_q);

`ifdef WBUF_CTRL_TIMEOUT_EN
  localparam int WDW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [WDW-1:0] wd_q, wd_d;
  logic           err_q, err_d;
  assign err = err_q;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYC;
`endif

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      k_q     <= '0;
      c_q     <= '0;
`ifdef WBUF_CTRL_TIMEOUT_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      c_q     <= c_d;
`ifdef WBUF_CTRL_TIMEOUT_EN
      wd_q    <= wd_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    c_d        = c_q;
    sram_req   = 1'b0;
    sdram_req  = 1'b0;
    buf_enable = 1'b0;
    buf_mode   = 3'b000;
    pair_valid = 1'b0;
    done       = 1'b0;
    busy       = (state_q != IDLE);
`ifdef WBUF_CTRL_TIMEOUT_EN
    wd_d       = '0;
    err_d      = err_q;
`endif
    // Loads strobe the buffer in the ack cycle itself so it captures on that edge.
    case (state_q)
      IDLE: begin
        if (start) begin
          k_d     = '0;
          c_d     = '0;
          state_d = F1S;
`ifdef WBUF_CTRL_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      F1S: begin
        sram_req = 1'b1;
        if (sram_ack) begin
          buf_enable = 1'b1;
          buf_mode   = 3'b001;
          state_d    = F1D;
        end
      end
      F1D: begin
        sdram_req = 1'b1;
        if (sdram_ack) begin
          buf_enable = 1'b1;
          buf_mode   = 3'b011;
          k_d        = k_q + 1'b1;
          state_d    = F2S;
        end
      end
      F2S, RS: begin
        sram_req = 1'b1;
        if (sram_ack) begin
          buf_enable = 1'b1;
          buf_mode   = 3'b010;
          state_d    = (state_q == F2S) ? F2D : RD;
        end
      end
      F2D, RD: begin
        sdram_req = 1'b1;
        if (sdram_ack) begin
          buf_enable = 1'b1;
          buf_mode   = 3'b100;
          k_d        = k_q + 1'b1;
          state_d    = READY;
        end
      end
      READY: begin
        pair_valid = 1'b1;
        if (advance) begin
          if (c_q == KW'(NUM_WORDS - 1)) begin
            state_d = DONE;
          end else begin
            c_d     = c_q + 1'b1;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        buf_enable = 1'b1;
        buf_mode   = 3'b101;
        // Once every index has been fetched the back pair stays empty.
        state_d    = (k_q < KW'(NUM_WORDS)) ? RS : READY;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef WBUF_CTRL_TIMEOUT_EN
    if ((sram_req && !sram_ack) || (sdram_req && !sdram_ack)) begin
      if (wd_q == WDW'(TIMEOUT_CYC - 1)) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else begin
        wd_d = wd_q + 1'b1;
      end
    end
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_wbuffer_ctrl.sv
// Bench for wbuffer_ctrl: per-cycle check against an expected operation list built per pass.
`default_nettype none

module tb_wbuffer_ctrl;

  localparam int unsigned AW = 16;
  localparam int unsigned NW = 4;
  localparam int unsigned SB = 'h100;
  localparam int unsigned DB = 'h200;
  localparam int unsigned TO = 10;

  localparam int K_LD  = 0;
  localparam int K_SH  = 1;
  localparam int K_ADV = 2;
  localparam int K_DN  = 3;

  logic          clk;
  logic          nrst, start, advance;
  logic          sram_req, sdram_req, sram_ack, sdram_ack;
  logic [AW-1:0] sram_addr, sdram_addr;
  logic          buf_enable, pair_valid, busy, done;
  logic [2:0]    buf_mode;
`ifdef WBUF_CTRL_TIMEOUT_EN
  logic          err;
`endif

  logic s_ack_r, d_ack_r, stray_d, hold_s;
  int   lat_s, lat_d, s_cnt, d_cnt;

  assign sram_ack  = s_ack_r;
  assign sdram_ack = d_ack_r | stray_d;

  wbuffer_ctrl #(
    .ADDR_W(AW), .NUM_WORDS(NW), .SRAM_BASE(SB), .SDRAM_BASE(DB), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .nrst(nrst), .start(start), .advance(advance),
    .sram_req(sram_req), .sram_addr(sram_addr), .sram_ack(sram_ack),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .buf_enable(buf_enable), .buf_mode(buf_mode), .pair_valid(pair_valid),
    .busy(busy), .done(done)
`ifdef WBUF_CTRL_TIMEOUT_EN
    , .err(err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    int kind;
    int mode;
    int idx;
  } op_t;

  op_t q[$];

  function automatic void push(input int kd, input int md, input int ix);
    op_t o;
    o.kind = kd;
    o.mode = md;
    o.idx  = ix;
    q.push_back(o);
  endfunction

  // Expected sequence of one pass: fill, then per consumed pair a shift and an optional refill.
  function automatic void build();
    int nxt;
    push(K_LD, 1, 0);
    push(K_LD, 3, 0);
    push(K_LD, 2, 1);
    push(K_LD, 4, 1);
    nxt = 2;
    for (int a = 1; a <= int'(NW); a++) begin
      push(K_ADV, 0, 0);
      if (a == int'(NW)) begin
        push(K_DN, 0, 0);
      end else begin
        push(K_SH, 5, 0);
        if (nxt < int'(NW)) begin
          push(K_LD, 2, nxt);
          push(K_LD, 4, nxt);
          nxt++;
        end
      end
    end
  endfunction

  int            pass_writes, shift_cnt, done_cnt, wcnt;
  logic [2:0]    log_mode [4];
  logic [AW-1:0] log_addr [4];
  logic          exp_err;
  op_t           h;
  logic          sreq_e, ack_e;

  always @(negedge clk) begin
    if (!nrst) begin
      q.delete();
      wcnt    = 0;
      exp_err = 1'b0;
      chk("rst_sram_req", sram_req, 0);
      chk("rst_sdram_req", sdram_req, 0);
      chk("rst_enable", buf_enable, 0);
      chk("rst_mode", buf_mode, 0);
      chk("rst_valid", pair_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
`ifdef WBUF_CTRL_TIMEOUT_EN
      chk("rst_err", err, 0);
`endif
    end else begin
      if (buf_enable) begin
        if (pass_writes < 4) begin
          log_mode[pass_writes] = buf_mode;
          log_addr[pass_writes] = (buf_mode == 3'b001 || buf_mode == 3'b010) ? sram_addr : sdram_addr;
        end
        pass_writes++;
        if (buf_mode == 3'b101) shift_cnt++;
      end
      if (done) done_cnt++;
`ifdef WBUF_CTRL_TIMEOUT_EN
      chk("err", err, exp_err);
`endif
      if (q.size() == 0) begin
        chk("idle_busy", busy, 0);
        chk("idle_sram_req", sram_req, 0);
        chk("idle_sdram_req", sdram_req, 0);
        chk("idle_enable", buf_enable, 0);
        chk("idle_mode", buf_mode, 0);
        chk("idle_valid", pair_valid, 0);
        chk("idle_done", done, 0);
        if (start) begin
          build();
          exp_err = 1'b0;
        end
      end else begin
        h = q[0];
        chk("busy", busy, 1);
        case (h.kind)
          K_LD: begin
            sreq_e = (h.mode == 1 || h.mode == 2);
            chk("ld_sram_req", sram_req, sreq_e);
            chk("ld_sdram_req", sdram_req, !sreq_e);
            chk("ld_valid", pair_valid, 0);
            chk("ld_done", done, 0);
            if (sreq_e) chk("ld_sram_addr", sram_addr, (SB + h.idx) & 'hFFFF);
            else        chk("ld_sdram_addr", sdram_addr, (DB + h.idx) & 'hFFFF);
            ack_e = sreq_e ? sram_ack : sdram_ack;
            if (ack_e) begin
              chk("ld_enable", buf_enable, 1);
              chk("ld_mode", buf_mode, h.mode);
              void'(q.pop_front());
              wcnt = 0;
            end else begin
              chk("wait_enable", buf_enable, 0);
              chk("wait_mode", buf_mode, 0);
              wcnt++;
`ifdef WBUF_CTRL_TIMEOUT_EN
              if (wcnt == int'(TO)) begin
                q.delete();
                wcnt    = 0;
                exp_err = 1'b1;
              end
`endif
            end
          end
          K_SH: begin
            chk("sh_enable", buf_enable, 1);
            chk("sh_mode", buf_mode, 5);
            chk("sh_sram_req", sram_req, 0);
            chk("sh_sdram_req", sdram_req, 0);
            chk("sh_valid", pair_valid, 0);
            chk("sh_done", done, 0);
            void'(q.pop_front());
          end
          K_ADV: begin
            chk("rdy_valid", pair_valid, 1);
            chk("rdy_enable", buf_enable, 0);
            chk("rdy_mode", buf_mode, 0);
            chk("rdy_sram_req", sram_req, 0);
            chk("rdy_sdram_req", sdram_req, 0);
            chk("rdy_done", done, 0);
            if (advance) void'(q.pop_front());
          end
          default: begin
            chk("dn_done", done, 1);
            chk("dn_valid", pair_valid, 0);
            chk("dn_enable", buf_enable, 0);
            chk("dn_mode", buf_mode, 0);
            chk("dn_sram_req", sram_req, 0);
            chk("dn_sdram_req", sdram_req, 0);
            void'(q.pop_front());
          end
        endcase
      end
    end
  end

  // Memory responders: ack arrives in request cycle lat+1.
  always @(posedge clk) begin
    #2;
    if (!nrst) begin
      s_ack_r = 1'b0; d_ack_r = 1'b0; s_cnt = 0; d_cnt = 0;
    end else begin
      if (sram_req && !hold_s) begin
        s_ack_r = (s_cnt >= lat_s);
        s_cnt   = s_ack_r ? 0 : s_cnt + 1;
      end else begin
        s_ack_r = 1'b0; s_cnt = 0;
      end
      if (sdram_req) begin
        d_ack_r = (d_cnt >= lat_d);
        d_cnt   = d_ack_r ? 0 : d_cnt + 1;
      end else begin
        d_ack_r = 1'b0; d_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!pair_valid && n < 200) begin tick(); n++; end
    chk(nm, pair_valid, 1);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 300) begin tick(); n++; end
    chk(nm, busy, 0);
  endtask

  task automatic adv_pulse();
    advance = 1'b1;
    tick();
    advance = 1'b0;
  endtask

  task automatic new_pass();
    pass_writes = 0;
    shift_cnt   = 0;
    done_cnt    = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int n;
    nrst = 1'b0; start = 1'b0; advance = 1'b0;
    stray_d = 1'b0; hold_s = 1'b0; s_ack_r = 1'b0; d_ack_r = 1'b0;
    lat_s = 2; lat_d = 2; s_cnt = 0; d_cnt = 0;
    wcnt = 0; exp_err = 1'b0;
    new_pass();
    repeat (3) tick();
    chk("rst_sram_addr", sram_addr, 'h100);
    chk("rst_sdram_addr", sdram_addr, 'h200);
    nrst = 1'b1;
    tick();

    // Pass 1: three-cycle acks, single advance pulses
    new_pass();
    start = 1'b1; tick(); start = 1'b0;
    chk("p1_first_req", sram_req, 1);
    chk("p1_first_addr", sram_addr, 'h100);
    wait_valid("p1_fill");
    chk("p1_w0_mode", log_mode[0], 1); chk("p1_w0_addr", log_addr[0], 'h100);
    chk("p1_w1_mode", log_mode[1], 3); chk("p1_w1_addr", log_addr[1], 'h200);
    chk("p1_w2_mode", log_mode[2], 2); chk("p1_w2_addr", log_addr[2], 'h101);
    chk("p1_w3_mode", log_mode[3], 4); chk("p1_w3_addr", log_addr[3], 'h201);
    repeat (4) begin
      wait_valid("p1_ready");
      adv_pulse();
    end
    wait_idle("p1_end");
    chk("p1_shifts", shift_cnt, 3);
    chk("p1_writes", pass_writes, 11);
    chk("p1_done_cnt", done_cnt, 1);

    // Pass 2: zero-wait acks, advance held high throughout
    lat_s = 0; lat_d = 0;
    new_pass();
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!pair_valid && n < 50) begin tick(); n++; end
    chk("p2_fill_cycles", n, 4);
    advance = 1'b1;
    wait_idle("p2_end");
    chk("p2_shifts", shift_cnt, 3);
    chk("p2_writes", pass_writes, 11);
    chk("p2_done_cnt", done_cnt, 1);

    // Pass 3: start with advance in IDLE, stray SDRAM ack, start in READY, advance in RS
    lat_s = 3; lat_d = 1;
    new_pass();
    start = 1'b1; tick(); start = 1'b0; advance = 1'b0;
    chk("p3_f1s_req", sram_req, 1);
    stray_d = 1'b1; tick(); tick(); stray_d = 1'b0;
    chk("p3_stray_hold", sram_req, 1);
    chk("p3_stray_nowrite", pass_writes, 0);
    wait_valid("p3_fill");
    start = 1'b1; tick(); start = 1'b0;
    chk("p3_start_ign", pair_valid, 1);
    adv_pulse();
    tick();
    advance = 1'b1; tick(); tick(); advance = 1'b0;
    chk("p3_rs_hold", sram_req, 1);
    chk("p3_rs_shifts", shift_cnt, 1);
    repeat (3) begin
      wait_valid("p3_ready");
      adv_pulse();
    end
    wait_idle("p3_end");
    chk("p3_shifts", shift_cnt, 3);
    chk("p3_writes", pass_writes, 11);
    chk("p3_done_cnt", done_cnt, 1);

    // Pass 4: reset asserted mid-F2S, start held through reset
    lat_s = 2; lat_d = 2;
    new_pass();
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!(sram_req && pass_writes == 2) && n < 100) begin tick(); n++; end
    chk("p4_reach_f2s", sram_req && pass_writes == 2, 1);
    #2 nrst = 1'b0;
    #1;
    chk("p4_async_sreq", sram_req, 0);
    chk("p4_async_busy", busy, 0);
    chk("p4_async_addr", sram_addr, 'h100);
    start = 1'b1;
    tick(); tick();
    nrst = 1'b1;
    tick(); start = 1'b0;
    chk("p4_restart_req", sram_req, 1);
    chk("p4_restart_addr", sram_addr, 'h100);
    new_pass();
    lat_s = 0; lat_d = 0;
    advance = 1'b1;
    wait_idle("p4_end");
    advance = 1'b0;
    chk("p4_done_cnt", done_cnt, 1);

`ifdef WBUF_CTRL_TIMEOUT_EN
    // Ack withheld in F2S until the watchdog fires
    lat_s = 2; lat_d = 2;
    new_pass();
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!(sram_req && pass_writes == 2) && n < 100) begin tick(); n++; end
    hold_s = 1'b1;
    wait_idle("to_idle");
    chk("to_err", err, 1);
    chk("to_no_done", done_cnt, 0);
    chk("to_req_low", sram_req, 0);
    hold_s = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    chk("to_err_clr", err, 0);
    advance = 1'b1;
    wait_idle("to_end");
    advance = 1'b0;
`endif

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
